rob_completion_arbiter: RTL and testbench
=========================================

ROB_COMPLETION_ARBITER -- requirements
Module: rob_completion_arbiter

Interface
REQ-001 Parameter DEPTH, default 2: entries per source FIFO; power of two, 2..8.
REQ-002 Parameter IDX_W, default 4: ROB index width.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 in_flush  input  1  pipeline flush (ROB exception recovery).
REQ-006 in_alu_valid / in_cache_valid / in_mul_valid  input  1 each  source has a completion.
REQ-007 in_<src>_idx  input  IDX_W  ROB entry index, one per source.
REQ-008 in_<src>_value  input  32  result value, one per source.
REQ-009 in_<src>_exc  input  3  exception code, one per source.
REQ-010 out_<src>_ready  output  1  source FIFO can accept, one per source.
REQ-011 in_rob_ready  input  1  ROB completion port accepts this cycle.
REQ-012 out_complete  output  1  completion valid toward ROB.
REQ-013 out_complete_idx / out_complete_value / out_exception  output  IDX_W / 32 / 3  granted completion payload.
REQ-014 out_src  output  2  granted source: 0 ALU, 1 cache, 2 MUL.
REQ-015 out_conflict_cnt  output  16  cycles with two or more FIFOs non-empty.

Function
REQ-016 Each source SHALL own a DEPTH-entry FIFO holding {idx, value, exc}; push when in_<src>_valid && out_<src>_ready.
REQ-017 out_<src>_ready SHALL be !full && !in_flush, derived from registered state only, never from in_<src>_valid.
REQ-018 No push at full; a pop from a full FIFO SHALL NOT make ready high in the same cycle.
REQ-019 Output stage SHALL be a single register; it loads when empty or when out_complete && in_rob_ready.
REQ-020 While out_complete && !in_rob_ready, all out_complete* and out_src SHALL hold stable.
REQ-021 Load selects one non-empty FIFO by round-robin: search order starts at source after last granted, wraps 2 -> 0.
REQ-022 A push accepted at edge t SHALL appear on out_complete no earlier than after edge t+1; empty-arbiter latency is exactly 2 edges.
REQ-023 Back-to-back: with in_rob_ready high and FIFOs non-empty, one completion SHALL issue every cycle.
REQ-024 Per-source order SHALL be FIFO; no cross-source ordering is guaranteed.
REQ-025 out_conflict_cnt SHALL increment when two or more FIFOs are non-empty and saturate at 16'hFFFF.
REQ-026 in_flush SHALL empty all FIFOs, clear the output register and reset the RR pointer at the next edge; concurrent pushes and ROB handshake are discarded; out_conflict_cnt is kept.
REQ-027 in_flush and reset together: reset SHALL win.

Reset
REQ-028 On reset, all FIFOs SHALL be empty and out_complete 0.
REQ-029 On reset, out_complete_idx, out_complete_value, out_exception and out_src SHALL be 0, and out_conflict_cnt 0.
REQ-030 On reset, out_<src>_ready SHALL be 1 from the first post-reset cycle.
REQ-031 On reset, the RR pointer SHALL select ALU first.
REQ-032 Reset mid-transfer SHALL drop all pending completions.

Configuration
REQ-033 Macro ROB_ARB_CACHE_PRIO_EN defined: cache FIFO SHALL have fixed top priority; ALU and MUL round-robin between themselves.
REQ-034 Macro ROB_ARB_CACHE_PRIO_EN undefined: pure three-way round-robin per REQ-021.

Verification
REQ-035 Single ALU push idx=3, value=0x1234, in_rob_ready=1 -> out_complete=1, idx=3, value=0x1234, out_src=0 exactly 2 edges later, for one cycle.
REQ-036 All three push on the same edge (idx 1/2/3), in_rob_ready=1 -> issue order ALU, cache, MUL on consecutive cycles; out_conflict_cnt=2.
REQ-037 in_rob_ready=0 for 5 cycles with ALU pushing every cycle, DEPTH=2 -> out_alu_ready low after 3 accepts; output held stable; all 3 delivered in order after release.
REQ-038 Flush with 2 entries per FIFO and out_complete=1 -> next cycle out_complete=0, all ready=1, no stale entry ever issued.
REQ-039 With ROB_ARB_CACHE_PRIO_EN, cache and MUL continuously non-empty -> cache granted every cycle, MUL starved; without the macro they alternate.
REQ-040 1000 cycles with all FIFOs non-empty -> out_conflict_cnt=1000; forced 70000 cycles -> 16'hFFFF.

Source files
------------

// File: rtl/rob_completion_arbiter.sv
// ----------------------------------------------------------------------------
// rob_completion_arbiter
//
// Merges completions from three execution sources (ALU, cache, MUL) into the
// single ROB completion port. Each source has its own small FIFO. One
// registered output stage feeds the ROB, and a round-robin pointer picks
// which FIFO refills that stage.
//
// Optional build macro:
//   ROB_ARB_CACHE_PRIO_EN - the cache FIFO always wins when it is non-empty.
//                           ALU and MUL round-robin between themselves.
//                           When undefined, all three sources round-robin.
//
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   in_flush                            drop everything pending (exception recovery)
//   in_<src>_valid/_idx/_value/_exc     completion from alu / cache / mul
//   out_<src>_ready                     source FIFO can accept this cycle
//   in_rob_ready                        ROB accepts the presented completion
//   out_complete, out_complete_idx,
//   out_complete_value, out_exception,
//   out_src                             registered completion toward the ROB
//   out_conflict_cnt                    saturating count of cycles with >=2
//                                       non-empty FIFOs
// ----------------------------------------------------------------------------

// Per-source completion FIFO. DEPTH must be a power of two, so the pointers
// wrap naturally.
module rob_arb_fifo #(
    parameter int DEPTH = 2,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [31:0]      i_value,
    input  logic [2:0]       i_exc,
    output logic [IDX_W-1:0] o_idx,
    output logic [31:0]      o_value,
    output logic [2:0]       o_exc,
    output logic             o_empty,
    output logic             o_full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [IDX_W-1:0] r_idx   [DEPTH];
    logic [31:0]      r_value [DEPTH];
    logic [2:0]       r_exc   [DEPTH];
    logic [PW-1:0]    r_rd;
    logic [PW-1:0]    r_wr;
    logic [CW-1:0]    r_cnt;

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + PW'(1);
            if (i_pop)  r_rd <= r_rd + PW'(1);
            case ({i_push, i_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // The storage needs no reset: the count alone decides what is live.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_idx[r_wr]   <= i_idx;
            r_value[r_wr] <= i_value;
            r_exc[r_wr]   <= i_exc;
        end
    end

    assign o_idx   = r_idx[r_rd];
    assign o_value = r_value[r_rd];
    assign o_exc   = r_exc[r_rd];
    assign o_empty = (r_cnt == '0);
    assign o_full  = (r_cnt == CW'(DEPTH));
endmodule

module rob_completion_arbiter #(
    parameter int DEPTH = 2,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_flush,
    input  logic             in_alu_valid,
    input  logic [IDX_W-1:0] in_alu_idx,
    input  logic [31:0]      in_alu_value,
    input  logic [2:0]       in_alu_exc,
    input  logic             in_cache_valid,
    input  logic [IDX_W-1:0] in_cache_idx,
    input  logic [31:0]      in_cache_value,
    input  logic [2:0]       in_cache_exc,
    input  logic             in_mul_valid,
    input  logic [IDX_W-1:0] in_mul_idx,
    input  logic [31:0]      in_mul_value,
    input  logic [2:0]       in_mul_exc,
    output logic             out_alu_ready,
    output logic             out_cache_ready,
    output logic             out_mul_ready,
    input  logic             in_rob_ready,
    output logic             out_complete,
    output logic [IDX_W-1:0] out_complete_idx,
    output logic [31:0]      out_complete_value,
    output logic [2:0]       out_exception,
    output logic [1:0]       out_src,
    output logic [15:0]      out_conflict_cnt
);
    localparam int NSRC = 3;
    localparam logic [1:0] SRC_ALU   = 2'd0;
    localparam logic [1:0] SRC_CACHE = 2'd1;
    localparam logic [1:0] SRC_MUL   = 2'd2;

    // Source-indexed views of the three request ports.
    logic [NSRC-1:0]             w_valid;
    logic [NSRC-1:0][IDX_W-1:0]  w_in_idx;
    logic [NSRC-1:0][31:0]       w_in_value;
    logic [NSRC-1:0][2:0]        w_in_exc;
    logic [NSRC-1:0][IDX_W-1:0]  w_hd_idx;
    logic [NSRC-1:0][31:0]       w_hd_value;
    logic [NSRC-1:0][2:0]        w_hd_exc;
    logic [NSRC-1:0]             w_empty;
    logic [NSRC-1:0]             w_full;
    logic [NSRC-1:0]             w_ne;
    logic [NSRC-1:0]             w_ready;
    logic [NSRC-1:0]             w_push;
    logic [NSRC-1:0]             w_pop;

    logic             r_out_valid;
    logic [IDX_W-1:0] r_out_idx;
    logic [31:0]      r_out_value;
    logic [2:0]       r_out_exc;
    logic [1:0]       r_out_src;
    logic [1:0]       r_last;
    logic [15:0]      r_conflict;

    logic             w_load;
    logic             w_gnt_vld;
    logic [1:0]       w_gnt;
    logic             w_conflict;

    assign w_valid    = {in_mul_valid, in_cache_valid, in_alu_valid};
    assign w_in_idx   = {in_mul_idx, in_cache_idx, in_alu_idx};
    assign w_in_value = {in_mul_value, in_cache_value, in_alu_value};
    assign w_in_exc   = {in_mul_exc, in_cache_exc, in_alu_exc};

    // Ready depends only on the registered fill level and the flush input.
    // It never depends on this cycle's valid or pop, so a pop from a full
    // FIFO does not raise ready in the same cycle.
    assign w_ready = ~w_full & {NSRC{~in_flush}};
    assign w_push  = w_valid & w_ready;
    assign w_ne    = ~w_empty;

    // The output stage refills whenever it is empty or is handing off.
    assign w_load = !r_out_valid || in_rob_ready;

    genvar s;
    generate
        for (s = 0; s < NSRC; s++) begin : g_src
            assign w_pop[s] = w_load && w_gnt_vld && (w_gnt == 2'(s)) && !in_flush;
            rob_arb_fifo #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_fifo (
                .clk     (clk),
                .reset   (reset),
                .i_clr   (in_flush),
                .i_push  (w_push[s]),
                .i_pop   (w_pop[s]),
                .i_idx   (w_in_idx[s]),
                .i_value (w_in_value[s]),
                .i_exc   (w_in_exc[s]),
                .o_idx   (w_hd_idx[s]),
                .o_value (w_hd_value[s]),
                .o_exc   (w_hd_exc[s]),
                .o_empty (w_empty[s]),
                .o_full  (w_full[s])
            );
        end
    endgenerate

    // Grant selection. r_last is the most recent round-robin winner, and the
    // search starts at the source after it.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = SRC_ALU;
`ifdef ROB_ARB_CACHE_PRIO_EN
        if (w_ne[SRC_CACHE]) begin
            w_gnt_vld = 1'b1;
            w_gnt     = SRC_CACHE;
        end else if (r_last == SRC_ALU) begin
            if (w_ne[SRC_MUL])      begin w_gnt_vld = 1'b1; w_gnt = SRC_MUL; end
            else if (w_ne[SRC_ALU]) begin w_gnt_vld = 1'b1; w_gnt = SRC_ALU; end
        end else begin
            if (w_ne[SRC_ALU])      begin w_gnt_vld = 1'b1; w_gnt = SRC_ALU; end
            else if (w_ne[SRC_MUL]) begin w_gnt_vld = 1'b1; w_gnt = SRC_MUL; end
        end
`else
        case (r_last)
            SRC_ALU: begin
                if (w_ne[SRC_CACHE])    begin w_gnt_vld = 1'b1; w_gnt = SRC_CACHE; end
                else if (w_ne[SRC_MUL]) begin w_gnt_vld = 1'b1; w_gnt = SRC_MUL; end
                else if (w_ne[SRC_ALU]) begin w_gnt_vld = 1'b1; w_gnt = SRC_ALU; end
            end
            SRC_CACHE: begin
                if (w_ne[SRC_MUL])        begin w_gnt_vld = 1'b1; w_gnt = SRC_MUL; end
                else if (w_ne[SRC_ALU])   begin w_gnt_vld = 1'b1; w_gnt = SRC_ALU; end
                else if (w_ne[SRC_CACHE]) begin w_gnt_vld = 1'b1; w_gnt = SRC_CACHE; end
            end
            default: begin
                if (w_ne[SRC_ALU])        begin w_gnt_vld = 1'b1; w_gnt = SRC_ALU; end
                else if (w_ne[SRC_CACHE]) begin w_gnt_vld = 1'b1; w_gnt = SRC_CACHE; end
                else if (w_ne[SRC_MUL])   begin w_gnt_vld = 1'b1; w_gnt = SRC_MUL; end
            end
        endcase
`endif
    end

    // Output register and round-robin pointer. A pointer value of MUL means
    // the next search starts at ALU.
    always_ff @(posedge clk) begin
        if (reset || in_flush) begin
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
            r_out_value <= '0;
            r_out_exc   <= '0;
            r_out_src   <= SRC_ALU;
            r_last      <= SRC_MUL;
        end else if (w_load) begin
            r_out_valid <= w_gnt_vld;
            if (w_gnt_vld) begin
                r_out_idx   <= w_hd_idx[w_gnt];
                r_out_value <= w_hd_value[w_gnt];
                r_out_exc   <= w_hd_exc[w_gnt];
                r_out_src   <= w_gnt;
`ifdef ROB_ARB_CACHE_PRIO_EN
                // Cache grants bypass the ALU/MUL rotation.
                if (w_gnt != SRC_CACHE) r_last <= w_gnt;
`else
                r_last <= w_gnt;
`endif
            end
        end
    end

    // Conflict counter. Flush does not clear it; only reset does.
    assign w_conflict = (w_ne[0] & w_ne[1]) | (w_ne[0] & w_ne[2]) | (w_ne[1] & w_ne[2]);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_conflict <= '0;
        end else if (w_conflict && (r_conflict != 16'hFFFF)) begin
            r_conflict <= r_conflict + 16'd1;
        end
    end

    assign out_alu_ready      = w_ready[SRC_ALU];
    assign out_cache_ready    = w_ready[SRC_CACHE];
    assign out_mul_ready      = w_ready[SRC_MUL];
    assign out_complete       = r_out_valid;
    assign out_complete_idx   = r_out_idx;
    assign out_complete_value = r_out_value;
    assign out_exception      = r_out_exc;
    assign out_src            = r_out_src;
    assign out_conflict_cnt   = r_conflict;
endmodule

// File: tb/tb_rob_completion_arbiter.sv
// Self-checking bench for rob_completion_arbiter. A queue-level reference
// model (per-source lists, one output slot, last-winner pointer) is stepped at
// every rising edge. Directed scenarios add explicit constant checks.
module tb_rob_completion_arbiter;
    localparam int DEPTH = 2;
    localparam int IDX_W = 4;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [31:0]      val;
        logic [2:0]       exc;
    } ent_t;

    logic clk = 1'b0;
    logic reset, in_flush, in_rob_ready;
    logic             tv   [3];
    logic [IDX_W-1:0] tidx [3];
    logic [31:0]      tval [3];
    logic [2:0]       texc [3];

    logic out_alu_ready, out_cache_ready, out_mul_ready, out_complete;
    logic [IDX_W-1:0] out_complete_idx;
    logic [31:0]      out_complete_value;
    logic [2:0]       out_exception;
    logic [1:0]       out_src;
    logic [15:0]      out_conflict_cnt;

    rob_completion_arbiter #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk(clk), .reset(reset), .in_flush(in_flush),
        .in_alu_valid(tv[0]),   .in_alu_idx(tidx[0]),   .in_alu_value(tval[0]),   .in_alu_exc(texc[0]),
        .in_cache_valid(tv[1]), .in_cache_idx(tidx[1]), .in_cache_value(tval[1]), .in_cache_exc(texc[1]),
        .in_mul_valid(tv[2]),   .in_mul_idx(tidx[2]),   .in_mul_value(tval[2]),   .in_mul_exc(texc[2]),
        .out_alu_ready(out_alu_ready), .out_cache_ready(out_cache_ready), .out_mul_ready(out_mul_ready),
        .in_rob_ready(in_rob_ready), .out_complete(out_complete),
        .out_complete_idx(out_complete_idx), .out_complete_value(out_complete_value),
        .out_exception(out_exception), .out_src(out_src), .out_conflict_cnt(out_conflict_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    ent_t mbuf [3][DEPTH];
    int   mcnt [3];
    bit   mv;
    ent_t mout;
    int   msrc, mlast, mconf;

    function automatic int pick();
`ifdef ROB_ARB_CACHE_PRIO_EN
        if (mcnt[1] > 0) return 1;
        if (mlast == 0) begin
            if (mcnt[2] > 0) return 2;
            if (mcnt[0] > 0) return 0;
        end else begin
            if (mcnt[0] > 0) return 0;
            if (mcnt[2] > 0) return 2;
        end
        return -1;
`else
        for (int k = 1; k <= 3; k++) begin
            int s;
            s = (mlast + k) % 3;
            if (mcnt[s] > 0) return s;
        end
        return -1;
`endif
    endfunction

    task automatic model_edge();
        int ne, s;
        bit acc [3];
        if (reset) begin
            for (int i = 0; i < 3; i++) mcnt[i] = 0;
            mv = 0; mout = '0; msrc = 0; mlast = 2; mconf = 0;
            return;
        end
        ne = 0;
        for (int i = 0; i < 3; i++) if (mcnt[i] > 0) ne++;
        if (ne >= 2 && mconf < 65535) mconf++;
        if (in_flush) begin
            for (int i = 0; i < 3; i++) mcnt[i] = 0;
            mv = 0; mout = '0; msrc = 0; mlast = 2;
            return;
        end
        for (int i = 0; i < 3; i++) acc[i] = tv[i] && (mcnt[i] < DEPTH);
        if (!mv || in_rob_ready) begin
            s = pick();
            if (s >= 0) begin
                mv = 1; mout = mbuf[s][0]; msrc = s;
                for (int j = 0; j < DEPTH - 1; j++) mbuf[s][j] = mbuf[s][j+1];
                mcnt[s]--;
`ifdef ROB_ARB_CACHE_PRIO_EN
                if (s != 1) mlast = s;
`else
                mlast = s;
`endif
            end else begin
                mv = 0;
            end
        end
        for (int i = 0; i < 3; i++) if (acc[i]) begin
            mbuf[i][mcnt[i]] = '{idx: tidx[i], val: tval[i], exc: texc[i]};
            mcnt[i]++;
        end
    endtask

    task automatic compare();
        chk("complete", out_complete, mv);
        if (mv) begin
            chk("idx", out_complete_idx, mout.idx);
            chk("value", out_complete_value, mout.val);
            chk("exc", out_exception, mout.exc);
            chk("src", out_src, msrc);
        end
        chk("rdy_alu", out_alu_ready, (mcnt[0] < DEPTH) && !in_flush);
        chk("rdy_cache", out_cache_ready, (mcnt[1] < DEPTH) && !in_flush);
        chk("rdy_mul", out_mul_ready, (mcnt[2] < DEPTH) && !in_flush);
        chk("conflict", out_conflict_cnt, mconf);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic idle_inputs();
        in_flush = 0; in_rob_ready = 0;
        for (int i = 0; i < 3; i++) begin
            tv[i] = 0; tidx[i] = '0; tval[i] = '0; texc[i] = '0;
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        cycle(); cycle();
        reset = 0;
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        do_reset();

        // Reset state
        chk("rst_complete", out_complete, 0);
        chk("rst_idx", out_complete_idx, 0);
        chk("rst_value", out_complete_value, 0);
        chk("rst_exc", out_exception, 0);
        chk("rst_src", out_src, 0);
        chk("rst_conf", out_conflict_cnt, 0);
        chk("rst_rdy", {out_alu_ready, out_cache_ready, out_mul_ready}, 3'b111);

        // Single ALU push: visible exactly two edges later, for one cycle
        in_rob_ready = 1;
        tv[0] = 1; tidx[0] = 4'd3; tval[0] = 32'h1234;
        cycle();
        tv[0] = 0;
        chk("lat_e1", out_complete, 0);
        cycle();
        chk("lat_e2", out_complete, 1);
        chk("lat_idx", out_complete_idx, 3);
        chk("lat_val", out_complete_value, 32'h1234);
        chk("lat_src", out_src, 0);
        cycle();
        chk("lat_e3", out_complete, 0);

        // All three push together: ALU, cache, MUL back-to-back
        do_reset();
        in_rob_ready = 1;
        for (int i = 0; i < 3; i++) begin tv[i] = 1; tidx[i] = 4'(i + 1); tval[i] = 32'(100 + i); end
        cycle();
        for (int i = 0; i < 3; i++) tv[i] = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("b2b_src", out_src, i);
            chk("b2b_idx", out_complete_idx, i + 1);
            chk("b2b_vld", out_complete, 1);
        end
        chk("b2b_conf", out_conflict_cnt, 2);

        // Backpressure: ROB stalled while ALU pushes every cycle
        do_reset();
        tv[0] = 1;
        for (int c = 0; c < 5; c++) begin
            tidx[0] = 4'(c); tval[0] = 32'(c * 16);
            cycle();
            if (c >= 2) chk("bp_rdy_low", out_alu_ready, 0);
            if (c >= 1) chk("bp_hold_idx", out_complete_idx, 0);
        end
        tv[0] = 0; in_rob_ready = 1;
        cycle(); chk("bp_order1", out_complete_idx, 1);
        cycle(); chk("bp_order2", out_complete_idx, 2);
        cycle(); chk("bp_drained", out_complete, 0);

        // Flush with two entries in every FIFO and a completion presented
        do_reset();
        for (int i = 0; i < 3; i++) begin tv[i] = 1; tidx[i] = 4'(8 + i); end
        cycle(); cycle(); cycle();
        chk("fl_pre_vld", out_complete, 1);
        in_flush = 1;
        cycle();
        in_flush = 0;
        for (int i = 0; i < 3; i++) tv[i] = 0;
        #1;
        chk("fl_vld", out_complete, 0);
        chk("fl_rdy", {out_alu_ready, out_cache_ready, out_mul_ready}, 3'b111);
        in_rob_ready = 1;
        for (int c = 0; c < 3; c++) begin cycle(); chk("fl_nostale", out_complete, 0); end

        // Cache and MUL continuously busy
        do_reset();
        in_rob_ready = 1; tv[1] = 1; tv[2] = 1;
        cycle();
        for (int k = 0; k < 6; k++) begin
            cycle();
            chk("cm_vld", out_complete, 1);
`ifdef ROB_ARB_CACHE_PRIO_EN
            chk("cm_src", out_src, 1);
`else
            chk("cm_src", out_src, (k % 2 == 0) ? 1 : 2);
`endif
        end

        // Randomized traffic with occasional flush and reset
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 3; i++) begin
                tv[i]   = ($urandom_range(0, 99) < 60);
                tidx[i] = 4'($urandom);
                tval[i] = $urandom;
                texc[i] = 3'($urandom);
            end
            in_rob_ready = ($urandom_range(0, 3) != 0);
            in_flush     = ($urandom_range(0, 49) == 0);
            reset        = ($urandom_range(0, 299) == 0);
            cycle();
        end
        reset = 0;

        // Conflict counter: exact count, then saturation
        do_reset();
        for (int i = 0; i < 3; i++) tv[i] = 1;
        cycle();
        for (int c = 0; c < 1000; c++) cycle();
        chk("conf_1000", out_conflict_cnt, 1000);
        for (int c = 0; c < 69000; c++) cycle();
        chk("conf_sat", out_conflict_cnt, 16'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
